// File: rtl/wb_burst_fetcher.sv
// wb_burst_fetcher: Wishbone read master that streams a linear block of
// 32-bit words into an internal show-ahead FIFO using incrementing bursts.
// A burst starts only after the FIFO has room for all of its words.
//
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   wb_*_o / wb_*_i           Wishbone master (read only, linear bursts)
//   start_i, base_adr_i,      transfer request; base address and word count
//   nwords_i                  are sampled with start_i in IDLE
//   clear_i                   synchronous abort plus FIFO flush
//   busy_o, done_o            transfer in progress / last word pushed pulse
//   rd_en_i, rd_data_o,       consumer side of the FIFO (show-ahead)
//   empty_o, level_o
module wb_burst_fetcher #(
  parameter int unsigned BURST_LEN  = 8,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned NWORDS_W   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  output logic                        wb_cyc_o,
  output logic                        wb_stb_o,
  output logic                        wb_we_o,
  output logic [3:0]                  wb_sel_o,
  output logic [31:0]                 wb_adr_o,
  output logic [2:0]                  wb_cti_o,
  output logic [1:0]                  wb_bte_o,
  input  logic [31:0]                 wb_dat_i,
  input  logic                        wb_ack_i,
  output logic [31:0]                 wb_dat_o,
  input  logic                        start_i,
  input  logic [31:0]                 base_adr_i,
  input  logic [NWORDS_W-1:0]         nwords_i,
  input  logic                        clear_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        rd_en_i,
  output logic [31:0]                 rd_data_o,
  output logic                        empty_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_LEN) + 1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_SPACE,
    S_BURST,
    S_FINISH
  } state_t;

  state_t              state_q;
  logic [31:0]         adr_q;
  logic [NWORDS_W-1:0] remaining_q;
  logic [BEAT_W-1:0]   beats_q;
  logic                cyc_q;
  logic [2:0]          cti_q;
  logic                busy_q;
  logic                done_q;

  logic [31:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]    count_q, count_d;
  logic [31:0]         head_q, head_d;
  logic                empty_q;

  logic [BEAT_W-1:0]   burst_len;
  logic                space_ok;
  logic                push;
  logic                pop;

  // Length of the next burst and whether the FIFO can absorb all of it.
  assign burst_len = (remaining_q < NWORDS_W'(BURST_LEN)) ? BEAT_W'(remaining_q)
                                                          : BEAT_W'(BURST_LEN);
  assign space_ok  = (LVL_W'(FIFO_DEPTH) - count_q) >= LVL_W'(burst_len);

  // cyc is only high in BURST, so an ack outside a burst is never pushed.
  assign push = (state_q == S_BURST) && wb_ack_i && !clear_i;
  assign pop  = rd_en_i && !empty_q && !clear_i;

  // Transfer control FSM.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      adr_q       <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      cyc_q       <= 1'b0;
      cti_q       <= CTI_CLASSIC;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (clear_i) begin
      state_q <= S_IDLE;
      beats_q <= '0;
      cyc_q   <= 1'b0;
      cti_q   <= CTI_CLASSIC;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            adr_q       <= base_adr_i & ~32'h3;
            remaining_q <= nwords_i;
            busy_q      <= 1'b1;
            state_q     <= (nwords_i == '0) ? S_FINISH : S_WAIT_SPACE;
          end
        end
        S_WAIT_SPACE: begin
          if (space_ok) begin
            cyc_q   <= 1'b1;
            beats_q <= burst_len;
            cti_q   <= (burst_len == BEAT_W'(1)) ? CTI_END : CTI_INCR;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (wb_ack_i) begin
            adr_q       <= adr_q + 32'd4;
            remaining_q <= remaining_q - NWORDS_W'(1);
            beats_q     <= beats_q - BEAT_W'(1);
            if (beats_q == BEAT_W'(1)) begin
              cyc_q   <= 1'b0;
              cti_q   <= CTI_CLASSIC;
              state_q <= (remaining_q == NWORDS_W'(1)) ? S_FINISH : S_WAIT_SPACE;
            end else if (beats_q == BEAT_W'(2)) begin
              // Next beat is the last one of this burst.
              cti_q <= CTI_END;
            end
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO next-state; the head register tracks mem[rd_ptr] one cycle ahead,
  // bypassing the write data when the new head is the slot being written.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PTR_W'(push);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    count_d  = count_q + LVL_W'(push) - LVL_W'(pop);
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    if (count_d == '0) begin
      head_d = '0;
    end else if (push && (rd_ptr_d == wr_ptr_q)) begin
      head_d = wb_dat_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wb_dat_i;
    end
  end

  // FIFO pointers, occupancy and registered head.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      empty_q  <= (count_d == '0);
    end
  end

  // A push into a full FIFO means the space reservation is broken.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   !(push && (count_q == LVL_W'(FIFO_DEPTH))));

  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = cyc_q;
  assign wb_we_o   = 1'b0;
  assign wb_sel_o  = 4'b1111;
  assign wb_adr_o  = adr_q;
  assign wb_cti_o  = cti_q;
  assign wb_bte_o  = 2'b00;
  assign wb_dat_o  = '0;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign rd_data_o = head_q;
  assign empty_o   = empty_q;
  assign level_o   = count_q;

endmodule

// File: tb/tb_wb_burst_fetcher.sv
// Self-checking bench for wb_burst_fetcher: table of transfers plus
// hand-written sequences for back-pressure, clear, reset and zero-length.
module tb_wb_burst_fetcher;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_adr_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i = 32'hDEAD_BEEF;
  logic        wb_ack_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        start_i = 1'b0;
  logic [31:0] base_adr_i = '0;
  logic [15:0] nwords_i = '0;
  logic        clear_i = 1'b0;
  logic        busy_o, done_o;
  logic        rd_en_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        empty_o;
  logic [5:0]  level_o;

  wb_burst_fetcher dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_adr_o(wb_adr_o), .wb_cti_o(wb_cti_o),
    .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_dat_o(wb_dat_o), .start_i(start_i), .base_adr_i(base_adr_i),
    .nwords_i(nwords_i), .clear_i(clear_i), .busy_o(busy_o),
    .done_o(done_o), .rd_en_i(rd_en_i), .rd_data_o(rd_data_o),
    .empty_o(empty_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Memory contents seen by the master at a given byte address.
  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A5A, a[17:2]};
  endfunction

  // Expected cti of beat k in a transfer of n words with 8-word bursts.
  function automatic logic [2:0] exp_cti(input int unsigned n, input int unsigned k);
    int unsigned first;
    int unsigned len;
    first = (k / 8) * 8;
    len   = (n - first < 8) ? (n - first) : 8;
    return ((k - first) == len - 1) ? 3'b111 : 3'b010;
  endfunction

  // Slave model: ack after wait_n stall cycles, adr/cti must hold while stalled.
  int          wait_n = 0;
  int          wcnt = 0;
  logic        in_beat = 1'b0;
  logic        force_ack = 1'b0;
  logic [31:0] hold_adr;
  logic [2:0]  hold_cti;

  always @(negedge clk_i) begin
    if (wb_cyc_o && wb_stb_o) begin
      if (in_beat) begin
        chk("stall_adr", wb_adr_o, hold_adr);
        chk("stall_cti", 32'(wb_cti_o), 32'(hold_cti));
      end else begin
        in_beat  = 1'b1;
        hold_adr = wb_adr_o;
        hold_cti = wb_cti_o;
        wcnt     = 0;
      end
      if (wcnt >= wait_n) begin
        wb_ack_i = 1'b1;
        wb_dat_i = word_of(wb_adr_o);
        in_beat  = 1'b0;
      end else begin
        wb_ack_i = 1'b0;
        wb_dat_i = 32'hDEAD_BEEF;
        wcnt++;
      end
    end else begin
      in_beat  = 1'b0;
      wb_ack_i = force_ack;
      wb_dat_i = force_ack ? 32'hBAD0_0000 : 32'hDEAD_BEEF;
    end
  end

  // Beat log and done counter, sampled on the active edge before updates.
  logic [31:0] adr_log[$];
  logic [2:0]  cti_log[$];
  int          acked_cnt = 0;
  int          burst_ends = 0;
  int          done_cnt = 0;

  always @(posedge clk_i) begin
    if (wb_ack_i && wb_cyc_o) begin
      adr_log.push_back(wb_adr_o);
      cti_log.push_back(wb_cti_o);
      acked_cnt++;
      if (wb_cti_o == 3'b111) burst_ends++;
    end
    if (done_o) done_cnt++;
  end

  task automatic flush_and_reset_logs();
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i = 1'b0;
    adr_log.delete();
    cti_log.delete();
    acked_cnt  = 0;
    burst_ends = 0;
  endtask

  task automatic start_xfer(input logic [31:0] base, input logic [15:0] n);
    base_adr_i = base;
    nwords_i   = n;
    start_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    int i;
    d0 = done_cnt;
    i  = 0;
    while (done_cnt == d0 && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk(name, 32'(done_cnt != d0), 32'd1);
  endtask

  task automatic wait_acks(input string name, input int n, input int budget);
    int i;
    i = 0;
    while (acked_cnt < n && i < budget) begin
      @(negedge clk_i);
      i++;
    end
    chk(name, 32'(acked_cnt >= n), 32'd1);
  endtask

  // Pop n words, checking each head against memory starting at base.
  task automatic pop_check(input string name, input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      chk(name, rd_data_o, word_of(base + 32'(k) * 32'd4));
      rd_en_i = 1'b1;
      @(negedge clk_i);
    end
    rd_en_i = 1'b0;
  endtask

  typedef struct {
    logic [31:0] base;
    int unsigned n;
    int          waits;
    int unsigned bursts;
    int unsigned level;
    logic [31:0] end_adr;
  } vec_t;

  vec_t vecs[5];
  int   d0;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{32'h0000_0100,  8, 0, 1,  8, 32'h0000_0120};
    vecs[1] = '{32'h0000_0000, 19, 0, 3, 19, 32'h0000_004C};
    vecs[2] = '{32'h0000_0203,  5, 2, 1,  5, 32'h0000_0214};
    vecs[3] = '{32'h0000_1000,  1, 0, 1,  1, 32'h0000_1004};
    vecs[4] = '{32'h0000_07FC, 12, 1, 2, 12, 32'h0000_082C};

    // Reset state.
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rst_stb", 32'(wb_stb_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_cti", 32'(wb_cti_o), 32'd0);
    chk("rst_adr", wb_adr_o, 32'd0);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_rd_data", rd_data_o, 32'd0);
    chk("const_we", 32'(wb_we_o), 32'd0);
    chk("const_sel", 32'(wb_sel_o), 32'hF);
    chk("const_bte", 32'(wb_bte_o), 32'd0);
    chk("const_dat_o", wb_dat_o, 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Table of complete transfers, no pops during the fetch.
    for (int v = 0; v < 5; v++) begin
      flush_and_reset_logs();
      wait_n = vecs[v].waits;
      d0 = done_cnt;
      start_xfer(vecs[v].base, 16'(vecs[v].n));
      chk("busy_after_start", 32'(busy_o), 32'd1);
      wait_done("xfer_done", 2000);
      repeat (2) @(negedge clk_i);
      chk("xfer_done_once", 32'(done_cnt - d0), 32'd1);
      chk("xfer_busy_low", 32'(busy_o), 32'd0);
      chk("xfer_cyc_low", 32'(wb_cyc_o), 32'd0);
      chk("xfer_level", 32'(level_o), 32'(vecs[v].level));
      chk("xfer_bursts", 32'(burst_ends), 32'(vecs[v].bursts));
      chk("xfer_end_adr", wb_adr_o, vecs[v].end_adr);
      chk("xfer_beats", 32'(adr_log.size()), 32'(vecs[v].n));
      for (int k = 0; k < adr_log.size() && k < int'(vecs[v].n); k++) begin
        chk("beat_adr", adr_log[k], (vecs[v].base & ~32'h3) + 32'(k) * 32'd4);
        chk("beat_cti", 32'(cti_log[k]), 32'(exp_cti(vecs[v].n, k)));
      end
      pop_check("xfer_data", vecs[v].base & ~32'h3, int'(vecs[v].n));
      chk("xfer_empty_after_pop", 32'(empty_o), 32'd1);
      chk("xfer_level_after_pop", 32'(level_o), 32'd0);
    end
    wait_n = 0;

    // Zero-length transfer: no bus cycle, done two cycles after start.
    flush_and_reset_logs();
    d0 = done_cnt;
    start_xfer(32'h0000_0040, 16'd0);
    chk("zero_busy_c1", 32'(busy_o), 32'd1);
    chk("zero_done_c1", 32'(done_o), 32'd0);
    chk("zero_cyc_c1", 32'(wb_cyc_o), 32'd0);
    @(negedge clk_i);
    chk("zero_done_c2", 32'(done_o), 32'd1);
    chk("zero_busy_c2", 32'(busy_o), 32'd0);
    chk("zero_cyc_c2", 32'(wb_cyc_o), 32'd0);
    @(negedge clk_i);
    chk("zero_done_c3", 32'(done_o), 32'd0);
    chk("zero_adr", wb_adr_o, 32'h0000_0040);
    chk("zero_done_once", 32'(done_cnt - d0), 32'd1);

    // start together with clear: clear wins.
    d0 = done_cnt;
    base_adr_i = 32'h0000_0800;
    nwords_i   = 16'd4;
    start_i    = 1'b1;
    clear_i    = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    clear_i = 1'b0;
    chk("clrstart_busy", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk_i);
    chk("clrstart_cyc", 32'(wb_cyc_o), 32'd0);
    chk("clrstart_level", 32'(level_o), 32'd0);
    chk("clrstart_no_done", 32'(done_cnt - d0), 32'd0);

    // FIFO back-pressure: 40 words into a 32-deep FIFO.
    flush_and_reset_logs();
    d0 = done_cnt;
    start_xfer(32'h0000_2000, 16'd40);
    wait_acks("bp_fill", 32, 1000);
    repeat (10) @(negedge clk_i);
    chk("bp_level_full", 32'(level_o), 32'd32);
    chk("bp_cyc_low", 32'(wb_cyc_o), 32'd0);
    chk("bp_busy", 32'(busy_o), 32'd1);
    chk("bp_acked", 32'(acked_cnt), 32'd32);
    chk("bp_no_done", 32'(done_cnt - d0), 32'd0);
    pop_check("bp_data_a", 32'h0000_2000, 8);
    wait_done("bp_done", 1000);
    chk("bp_level_end", 32'(level_o), 32'd32);
    chk("bp_bursts", 32'(burst_ends), 32'd5);
    pop_check("bp_data_b", 32'h0000_2020, 32);
    chk("bp_empty", 32'(empty_o), 32'd1);

    // clear on the 4th beat, stray acks afterwards, then a fresh transfer.
    flush_and_reset_logs();
    d0 = done_cnt;
    start_xfer(32'h0000_0300, 16'd8);
    wait_acks("clr_reach_beat4", 3, 200);
    clear_i = 1'b1;
    @(negedge clk_i);
    clear_i   = 1'b0;
    force_ack = 1'b1;
    chk("clr_cyc", 32'(wb_cyc_o), 32'd0);
    chk("clr_stb", 32'(wb_stb_o), 32'd0);
    chk("clr_level", 32'(level_o), 32'd0);
    chk("clr_empty", 32'(empty_o), 32'd1);
    chk("clr_busy", 32'(busy_o), 32'd0);
    repeat (3) @(negedge clk_i);
    force_ack = 1'b0;
    @(negedge clk_i);
    chk("clr_stray_level", 32'(level_o), 32'd0);
    chk("clr_no_done", 32'(done_cnt - d0), 32'd0);
    start_xfer(32'h0000_0504, 16'd3);
    wait_done("clr_new_done", 200);
    @(negedge clk_i);
    chk("clr_new_level", 32'(level_o), 32'd3);
    pop_check("clr_new_data", 32'h0000_0504, 3);

    // Asynchronous reset mid-burst.
    flush_and_reset_logs();
    wait_n = 1;
    start_xfer(32'h0000_0600, 16'd16);
    wait_acks("rstmid_reach", 3, 200);
    #2;
    rst_i     = 1'b1;
    force_ack = 1'b1;
    #1;
    chk("rstmid_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstmid_stb", 32'(wb_stb_o), 32'd0);
    chk("rstmid_busy", 32'(busy_o), 32'd0);
    chk("rstmid_cti", 32'(wb_cti_o), 32'd0);
    chk("rstmid_adr", wb_adr_o, 32'd0);
    chk("rstmid_level", 32'(level_o), 32'd0);
    chk("rstmid_empty", 32'(empty_o), 32'd1);
    chk("rstmid_rd_data", rd_data_o, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    force_ack = 1'b0;
    @(negedge clk_i);
    chk("rstmid_after_level", 32'(level_o), 32'd0);
    chk("rstmid_after_cyc", 32'(wb_cyc_o), 32'd0);
    chk("rstmid_after_busy", 32'(busy_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
